data_mem_ctrl: RTL and testbench

Data-memory controller placed directly downstream of the MEM stage of the 5-stage MIPS pipeline. It accepts the MEM-stage access request (`mem_ren`, `mem_wen`, `mem_addr`, `mem_dout`) and drives a synchronous word-addressed RAM that has a fixed read latency. It returns read data on `mem_din` and asserts `mem_stall` to the pipeline controller until the access completes. It also flags misaligned and out-of-range accesses on `mem_err` and suppresses them.

---
 rtl/data_mem_ctrl_if.sv | 35 +++
 rtl/data_mem_ctrl.sv | 91 +++++++++
 tb/tb_data_mem_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: groups the MEM-stage request/response signals and the
// RAM port of the data-memory controller into one bundle.
//   Pipeline side : mem_en, mem_ren, mem_wen, mem_addr, mem_dout -> controller
//                   mem_din, mem_stall, mem_err                  <- controller
//   RAM side      : ram_en, ram_we, ram_addr, ram_wdata          <- controller
//                   ram_rdata                                    -> controller
// modport slave  : the controller's view.
// modport master : the environment's view (pipeline plus RAM).
interface data_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  mem_en;
    logic                  mem_ren;
    logic                  mem_wen;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_dout;
    logic [31:0]           mem_din;
    logic                  mem_stall;
    logic                  mem_err;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    modport master (
        output mem_en, mem_ren, mem_wen, mem_addr, mem_dout, ram_rdata,
        input  mem_din, mem_stall, mem_err, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  mem_en, mem_ren, mem_wen, mem_addr, mem_dout, ram_rdata,
        output mem_din, mem_stall, mem_err, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory controller behind the MEM stage of a 5-stage
// MIPS pipeline. Turns a MEM-stage load/store into a single strobe on a
// synchronous word-addressed RAM with a fixed read latency, stalls the
// pipeline until the access completes, and rejects misaligned,
// out-of-range or read+write requests with a one-cycle mem_err pulse.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - data_mem_ctrl_if.slave (pipeline request/response + RAM port)
// Parameters:
//   ADDR_WIDTH - RAM word-address width (must match the interface)
//   RAM_LAT    - RAM read latency in cycles, 1..4
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int RAM_LAT    = 1
) (
    input logic            clk,
    input logic            rst,
    data_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] rdata_q;

    logic req;
    logic bad;
    logic good;

    always_comb begin
        req  = bus.mem_ren | bus.mem_wen;
        // Upper bits are checked with a shift so a full-width RAM needs no
        // zero-width slice.
        bad  = (bus.mem_addr[1:0] != 2'b00)
             || ((bus.mem_addr >> (ADDR_WIDTH + 2)) != 32'd0)
             || (bus.mem_ren & bus.mem_wen);
        // Requests are only accepted in IDLE; the one still presented in
        // WAIT/DONE is the access already in flight.
        good = (state == S_IDLE) && req && !bad && !rst;
    end

    // Outputs are gated by rst so everything reads 0 while reset is held,
    // even though the state register only clears on the edge.
    assign bus.ram_en    = good;
    assign bus.ram_we    = good & bus.mem_wen;
    assign bus.ram_addr  = bus.mem_addr[ADDR_WIDTH+1:2];
    assign bus.ram_wdata = bus.mem_dout;
    assign bus.mem_err   = (state == S_IDLE) && req && bad && !rst;
    assign bus.mem_stall = good | ((state == S_WAIT) && !rst);
    assign bus.mem_din   = ((state == S_DONE) && !rst) ? rdata_q : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            rdata_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (good) begin
                        if (bus.mem_wen) begin
                            rdata_q <= 32'd0;
                            state   <= S_DONE;
                        end else begin
                            // Data lands RAM_LAT cycles after the strobe;
                            // WAIT lasts exactly that long.
                            cnt   <= 3'(RAM_LAT);
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        rdata_q <= bus.ram_rdata;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Another stall source may hold the pipeline; keep the
                    // result until the MEM stage actually advances.
                    if (bus.mem_en) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl: three instances with RAM_LAT = 1, 3
// and 4, each with a behavioural RAM of matching latency.
module tb_data_mem_ctrl;
    localparam logic [31:0] FILL = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   n1 = 0;
    int   n3 = 0;
    int   n4 = 0;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_WIDTH(10)) b1 ();
    data_mem_ctrl_if #(.ADDR_WIDTH(10)) b3 ();
    data_mem_ctrl_if #(.ADDR_WIDTH(10)) b4 ();

    data_mem_ctrl #(.ADDR_WIDTH(10), .RAM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    data_mem_ctrl #(.ADDR_WIDTH(10), .RAM_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
    data_mem_ctrl #(.ADDR_WIDTH(10), .RAM_LAT(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    // Behavioural RAMs: read data appears RAM_LAT cycles after the strobe,
    // FILL in every other cycle so a mistimed capture is visible.
    logic [31:0] m1 [1024];
    logic [31:0] m3 [1024];
    logic [31:0] m4 [1024];
    logic [31:0] p1 [1];
    logic [31:0] p3 [3];
    logic [31:0] p4 [4];

    always @(posedge clk) begin
        if (b1.ram_en === 1'b1 && b1.ram_we === 1'b1) m1[b1.ram_addr] <= b1.ram_wdata;
        p1[0] <= (b1.ram_en === 1'b1 && b1.ram_we === 1'b0) ? m1[b1.ram_addr] : FILL;
        if (b1.ram_en === 1'b1) n1 <= n1 + 1;
    end

    always @(posedge clk) begin
        if (b3.ram_en === 1'b1 && b3.ram_we === 1'b1) m3[b3.ram_addr] <= b3.ram_wdata;
        p3[0] <= (b3.ram_en === 1'b1 && b3.ram_we === 1'b0) ? m3[b3.ram_addr] : FILL;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        if (b3.ram_en === 1'b1) n3 <= n3 + 1;
    end

    always @(posedge clk) begin
        if (b4.ram_en === 1'b1 && b4.ram_we === 1'b1) m4[b4.ram_addr] <= b4.ram_wdata;
        p4[0] <= (b4.ram_en === 1'b1 && b4.ram_we === 1'b0) ? m4[b4.ram_addr] : FILL;
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
        if (b4.ram_en === 1'b1) n4 <= n4 + 1;
    end

    assign b1.ram_rdata = p1[0];
    assign b3.ram_rdata = p3[2];
    assign b4.ram_rdata = p4[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
        end
    endtask

    task automatic drv(input int d, input logic en, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] dout);
        case (d)
            1: begin b1.mem_en = en; b1.mem_ren = ren; b1.mem_wen = wen; b1.mem_addr = addr; b1.mem_dout = dout; end
            3: begin b3.mem_en = en; b3.mem_ren = ren; b3.mem_wen = wen; b3.mem_addr = addr; b3.mem_dout = dout; end
            default: begin b4.mem_en = en; b4.mem_ren = ren; b4.mem_wen = wen; b4.mem_addr = addr; b4.mem_dout = dout; end
        endcase
    endtask

    task automatic exp(input string tag, input int d, input logic en, input logic we,
                       input logic stall, input logic err, input logic [31:0] din);
        logic        o_en, o_we, o_st, o_er;
        logic [31:0] o_din;
        case (d)
            1: begin o_en = b1.ram_en; o_we = b1.ram_we; o_st = b1.mem_stall; o_er = b1.mem_err; o_din = b1.mem_din; end
            3: begin o_en = b3.ram_en; o_we = b3.ram_we; o_st = b3.mem_stall; o_er = b3.mem_err; o_din = b3.mem_din; end
            default: begin o_en = b4.ram_en; o_we = b4.ram_we; o_st = b4.mem_stall; o_er = b4.mem_err; o_din = b4.mem_din; end
        endcase
        chk({tag, ".ram_en"},    32'(o_en), 32'(en));
        chk({tag, ".ram_we"},    32'(o_we), 32'(we));
        chk({tag, ".mem_stall"}, 32'(o_st), 32'(stall));
        chk({tag, ".mem_err"},   32'(o_er), 32'(err));
        chk({tag, ".mem_din"},   o_din,     din);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drv(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset with a request pending: nothing may escape
        tick(); drv(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0); #1;
        exp("rst_gated", 1, 0, 0, 0, 0, 32'h0);
        tick(); rst = 1'b0; drv(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0); #1;
        exp("post_rst", 1, 0, 0, 0, 0, 32'h0);

        // RAM_LAT=1: store DEADBEEF at 0x10, then load it back
        tick(); drv(1, 1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF); #1;
        exp("l1_wr_c0", 1, 1, 1, 1, 0, 32'h0);
        chk("l1_wr_addr", 32'(b1.ram_addr), 32'd4);
        tick(); #1;
        exp("l1_wr_done", 1, 0, 0, 0, 0, 32'h0);
        tick(); drv(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0); #1;
        exp("l1_rd_c0", 1, 1, 0, 1, 0, 32'h0);
        chk("l1_rd_addr", 32'(b1.ram_addr), 32'd4);
        tick(); #1;
        exp("l1_rd_c1", 1, 0, 0, 1, 0, 32'h0);
        // DONE held by mem_en=0 for three cycles
        tick(); drv(1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0); #1;
        exp("l1_rd_done", 1, 0, 0, 0, 0, 32'hDEADBEEF);
        tick(); #1;
        exp("l1_hold2", 1, 0, 0, 0, 0, 32'hDEADBEEF);
        tick(); drv(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0); #1;
        exp("l1_hold3", 1, 0, 0, 0, 0, 32'hDEADBEEF);
        tick(); drv(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0); #1;
        exp("l1_idle", 1, 0, 0, 0, 0, 32'h0);

        // Bad requests on the RAM_LAT=1 instance
        tick(); drv(1, 1'b1, 1'b1, 1'b0, 32'h22, 32'h0); #1;
        exp("err_misalign", 1, 0, 0, 0, 1, 32'h0);
        tick(); drv(1, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h55); #1;
        exp("err_range", 1, 0, 0, 0, 1, 32'h0);
        tick(); drv(1, 1'b1, 1'b1, 1'b0, 32'h80000010, 32'h0); #1;
        exp("err_range_hi", 1, 0, 0, 0, 1, 32'h0);
        tick(); drv(1, 1'b1, 1'b1, 1'b1, 32'h4, 32'h0); #1;
        exp("err_both", 1, 0, 0, 0, 1, 32'h0);
        tick(); drv(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0); #1;
        exp("err_clear", 1, 0, 0, 0, 0, 32'h0);
        chk("l1_strobes", 32'(n1), 32'd2);

        // RAM_LAT=3: store 12345678 at 0x20, then load it back
        tick(); drv(3, 1'b1, 1'b0, 1'b1, 32'h20, 32'h12345678); #1;
        exp("l3_wr_c0", 3, 1, 1, 1, 0, 32'h0);
        chk("l3_wr_addr", 32'(b3.ram_addr), 32'd8);
        tick(); #1;
        exp("l3_wr_done", 3, 0, 0, 0, 0, 32'h0);
        tick(); drv(3, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0); #1;
        exp("l3_rd_c0", 3, 1, 0, 1, 0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            exp($sformatf("l3_rd_c%0d", i), 3, 0, 0, 1, 0, 32'h0);
        end
        tick(); #1;
        exp("l3_rd_done", 3, 0, 0, 0, 0, 32'h12345678);
        tick(); drv(3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0); #1;
        exp("l3_idle", 3, 0, 0, 0, 0, 32'h0);
        chk("l3_strobes", 32'(n3), 32'd2);

        // RAM_LAT=4: seed two words, then reset in the second WAIT cycle
        tick(); drv(4, 1'b1, 1'b0, 1'b1, 32'h0, 32'h11112222); #1;
        exp("l4_wr0", 4, 1, 1, 1, 0, 32'h0);
        tick(); #1;
        exp("l4_wr0_done", 4, 0, 0, 0, 0, 32'h0);
        tick(); drv(4, 1'b1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D); #1;
        exp("l4_wr1", 4, 1, 1, 1, 0, 32'h0);
        chk("l4_wr1_addr", 32'(b4.ram_addr), 32'd16);
        tick(); #1;
        exp("l4_wr1_done", 4, 0, 0, 0, 0, 32'h0);
        tick(); drv(4, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0); #1;
        exp("l4_rd_c0", 4, 1, 0, 1, 0, 32'h0);
        tick(); #1;
        exp("l4_wait1", 4, 0, 0, 1, 0, 32'h0);
        tick(); rst = 1'b1; drv(4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0); #1;
        exp("l4_in_rst", 4, 0, 0, 0, 0, 32'h0);
        tick(); rst = 1'b0; #1;
        exp("l4_after_rst", 4, 0, 0, 0, 0, 32'h0);
        // Fresh load at 0x0; stale CAFEF00D arrives during this IDLE cycle
        tick(); drv(4, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0); #1;
        exp("l4_new_c0", 4, 1, 0, 1, 0, 32'h0);
        chk("l4_new_addr", 32'(b4.ram_addr), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick(); #1;
            exp($sformatf("l4_new_c%0d", i), 4, 0, 0, 1, 0, 32'h0);
        end
        tick(); #1;
        exp("l4_new_done", 4, 0, 0, 0, 0, 32'h11112222);
        tick(); drv(4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0); #1;
        exp("l4_idle", 4, 0, 0, 0, 0, 32'h0);
        chk("l4_strobes", 32'(n4), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
